// File: rtl/fetch_queue_unit_if.sv
// Bundle of the fetch unit's memory-port, redirect and decode-side signals.
// The master modport is the fetch unit's view; the slave modport is its environment.
interface fetch_queue_unit_if #(
    parameter int width = 32
);
    logic             imem_read;
    logic [width-1:0] imem_address;
    logic             imem_resp;
    logic [width-1:0] imem_rdata;
    logic             redirect;
    logic [width-1:0] redirect_pc;
    logic             deq;
    logic             valid;
    logic [width-1:0] instruction;
    logic [width-1:0] pc;

    modport master (
        output imem_read, imem_address, valid, instruction, pc,
        input  imem_resp, imem_rdata, redirect, redirect_pc, deq
    );

    modport slave (
        input  imem_read, imem_address, valid, instruction, pc,
        output imem_resp, imem_rdata, redirect, redirect_pc, deq
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Sequential (predict-not-taken) instruction fetcher with a single outstanding
// memory read, a circular {instruction, pc} queue and redirect-driven flushing.
module fetch_queue_unit #(
    parameter int               width    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [width-1:0] RESET_PC = 32'h00000060
) (
    input logic                clk,
    input logic                rst,
    fetch_queue_unit_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // DISCARD waits out the response of a read that a redirect made stale.
    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [width-1:0] r_fetchPc;
    logic [width-1:0] w_fetchPcNext;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_countNext;
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [width-1:0] r_instrMem [DEPTH];
    logic [width-1:0] r_pcMem    [DEPTH];
    logic             w_enq;
    logic             w_deq;

    assign w_enq = (r_state == REQ) && bus.imem_resp && !bus.redirect;
    assign w_deq = bus.deq && (r_count != '0) && !bus.redirect;

    always_comb begin
        w_countNext = r_count;
        if (w_enq && !w_deq) begin
            w_countNext = r_count + CW'(1);
        end else if (!w_enq && w_deq) begin
            w_countNext = r_count - CW'(1);
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_fetchPcNext = r_fetchPc;
        if (bus.redirect) begin
            w_fetchPcNext = bus.redirect_pc;
        end else if (w_enq) begin
            w_fetchPcNext = r_fetchPc + width'(4);
        end
        unique case (r_state)
            IDLE: begin
                if (!bus.redirect && (r_count < FULL)) w_stateNext = REQ;
            end
            REQ: begin
                // A response coinciding with a redirect closes the read, so no DISCARD.
                if (bus.redirect) begin
                    w_stateNext = bus.imem_resp ? IDLE : DISCARD;
                end else if (bus.imem_resp) begin
                    w_stateNext = (w_countNext < FULL) ? REQ : IDLE;
                end
            end
            DISCARD: begin
                if (bus.imem_resp) w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_fetchPc <= RESET_PC;
            r_count   <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instrMem[i] <= '0;
                r_pcMem[i]    <= '0;
            end
        end else begin
            r_state   <= w_stateNext;
            r_fetchPc <= w_fetchPcNext;
            if (bus.redirect) begin
                r_count <= '0;
                r_head  <= '0;
                r_tail  <= '0;
            end else begin
                r_count <= w_countNext;
                if (w_enq) begin
                    r_instrMem[r_tail] <= bus.imem_rdata;
                    r_pcMem[r_tail]    <= r_fetchPc;
                    r_tail             <= r_tail + AW'(1);
                end
                if (w_deq) begin
                    r_head <= r_head + AW'(1);
                end
            end
        end
    end

    assign bus.imem_read    = (r_state == REQ);
    assign bus.imem_address = r_fetchPc;
    assign bus.valid        = (r_count != '0);
    assign bus.instruction  = r_instrMem[r_head];
    assign bus.pc           = r_pcMem[r_head];
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: a directed vector table, short
// hand-written corner sequences, then random traffic against a queue-based model.
module tb_fetch_queue_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h00000060;

    logic clk;
    logic rst;

    fetch_queue_unit_if #(.width(32)) bus ();

    fetch_queue_unit #(
        .width(32),
        .DEPTH(DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        redirect;
        logic [31:0] rpc;
        logic        deq;
        logic        resp;
        logic [31:0] rdata;
        logic        eRead;
        logic [31:0] eAddr;
        logic        eValid;
        logic        eHead;
        logic [31:0] ePc;
        logic [31:0] eInstr;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    vec_t   vecs[$];
    entry_t mq[$];
    logic [31:0] mPc;
    bit          mBusy;
    bit          mStale;
    int          checkCount = 0;
    int          passCount  = 0;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'h5A5A1234;
    endfunction

    task automatic addVec(input logic r, input logic rd, input logic [31:0] rpc,
                          input logic dq, input logic rs, input logic [31:0] rdat,
                          input logic er, input logic [31:0] ea, input logic ev,
                          input logic eh, input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v = '{r, rd, rpc, dq, rs, rdat, er, ea, ev, eh, ep, ei};
        vecs.push_back(v);
    endtask

    // Reference behaviour: a request is either outstanding (busy), owed but unwanted (stale), or absent.
    task automatic modelStep(input logic r, input logic rd, input logic [31:0] rpc,
                             input logic dq, input logic rs, input logic [31:0] rdat);
        int preSize;
        bit startIdle;
        entry_t e;
        preSize   = mq.size();
        startIdle = !mBusy && !mStale;
        if (r) begin
            mq.delete();
            mPc    = RESET_PC;
            mBusy  = 0;
            mStale = 0;
        end else if (rd) begin
            mq.delete();
            if (mBusy) mStale = !rs;
            else if (mStale && rs) mStale = 0;
            mBusy = 0;
            mPc   = rpc;
        end else begin
            if (dq && mq.size() > 0) void'(mq.pop_front());
            if (mBusy && rs) begin
                e.instr = rdat;
                e.pc    = mPc;
                mq.push_back(e);
                mPc   = mPc + 32'd4;
                mBusy = (mq.size() < DEPTH);
            end else if (mStale && rs) begin
                mStale = 0;
            end else if (startIdle) begin
                mBusy = (preSize < DEPTH);
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rd, input logic [31:0] rpc,
                                 input logic dq, input logic rs, input logic [31:0] rdat);
        rst             = r;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.deq         = dq;
        bus.imem_resp   = rs;
        bus.imem_rdata  = rdat;
        modelStep(r, rd, rpc, dq, rs, rdat);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".imem_read"}, {31'd0, bus.imem_read}, {31'd0, mBusy});
        checkVal({tag, ".imem_address"}, bus.imem_address, mPc);
        checkVal({tag, ".valid"}, {31'd0, bus.valid}, {31'd0, (mq.size() > 0)});
        if (mq.size() > 0) begin
            checkVal({tag, ".pc"}, bus.pc, mq[0].pc);
            checkVal({tag, ".instruction"}, bus.instruction, mq[0].instr);
        end
    endtask

    initial begin
        bit          memPending;
        logic [31:0] memAddr;
        int          memWait;
        logic        r, rd, dq, rs;
        logic [31:0] rpc, rdat;

        // r rd rpc dq rs rdata | read addr valid head pc instr
        addVec(1, 0, 0, 0, 0, 0,                         0, 32'h60, 0, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0,                         1, 32'h60, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 1, pat(32'h60),               1, 32'h64, 1, 1, 32'h60, pat(32'h60));
        addVec(0, 0, 0, 0, 1, pat(32'h64),               1, 32'h68, 1, 1, 32'h60, pat(32'h60));
        addVec(0, 0, 0, 0, 1, pat(32'h68),               1, 32'h6C, 1, 1, 32'h60, pat(32'h60));
        addVec(0, 0, 0, 0, 1, pat(32'h6C),               0, 32'h70, 1, 1, 32'h60, pat(32'h60));
        addVec(0, 0, 0, 0, 0, 0,                         0, 32'h70, 1, 1, 32'h60, pat(32'h60));
        addVec(0, 0, 0, 1, 0, 0,                         0, 32'h70, 1, 1, 32'h64, pat(32'h64));
        addVec(0, 0, 0, 0, 0, 0,                         1, 32'h70, 1, 1, 32'h64, pat(32'h64));
        addVec(0, 0, 0, 1, 1, pat(32'h70),               1, 32'h74, 1, 1, 32'h68, pat(32'h68));
        addVec(0, 1, 32'h200, 0, 0, 0,                   0, 32'h200, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0,                         0, 32'h200, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 1, pat(32'h74),               0, 32'h200, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0,                         1, 32'h200, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 1, pat(32'h200),              1, 32'h204, 1, 1, 32'h200, pat(32'h200));
        addVec(0, 1, 32'h400, 0, 1, pat(32'h204),        0, 32'h400, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0,                         1, 32'h400, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 1, pat(32'h400),              1, 32'h404, 1, 1, 32'h400, pat(32'h400));
        addVec(0, 1, 32'hFFFFFFFC, 1, 0, 0,              0, 32'hFFFFFFFC, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 1, pat(32'h404),              0, 32'hFFFFFFFC, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0,                         1, 32'hFFFFFFFC, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 1, pat(32'hFFFFFFFC),         1, 32'h0, 1, 1, 32'hFFFFFFFC, pat(32'hFFFFFFFC));
        addVec(0, 0, 0, 1, 1, pat(32'h0),                1, 32'h4, 1, 1, 32'h0, pat(32'h0));
        addVec(1, 0, 0, 0, 1, pat(32'h4),                0, 32'h60, 0, 1, 0, 0);
        addVec(0, 0, 0, 0, 1, pat(32'h4),                1, 32'h60, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0,                         1, 32'h60, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].redirect, vecs[i].rpc,
                          vecs[i].deq, vecs[i].resp, vecs[i].rdata);
            checkVal($sformatf("vec%0d.imem_read", i), {31'd0, bus.imem_read}, {31'd0, vecs[i].eRead});
            checkVal($sformatf("vec%0d.imem_address", i), bus.imem_address, vecs[i].eAddr);
            checkVal($sformatf("vec%0d.valid", i), {31'd0, bus.valid}, {31'd0, vecs[i].eValid});
            if (vecs[i].eHead) begin
                checkVal($sformatf("vec%0d.pc", i), bus.pc, vecs[i].ePc);
                checkVal($sformatf("vec%0d.instruction", i), bus.instruction, vecs[i].eInstr);
            end
        end

        // Reset while a read is outstanding with two entries queued; a late response must be ignored.
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, pat(32'h60));
        applyStimulus(0, 0, 0, 0, 1, pat(32'h64));
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("midreq.before");
        checkVal("midreq.before.pc", bus.pc, 32'h60);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkVal("midreq.rst.imem_read", {31'd0, bus.imem_read}, 32'd0);
        checkVal("midreq.rst.imem_address", bus.imem_address, 32'h60);
        checkVal("midreq.rst.valid", {31'd0, bus.valid}, 32'd0);
        checkVal("midreq.rst.pc", bus.pc, 32'd0);
        checkVal("midreq.rst.instruction", bus.instruction, 32'd0);
        applyStimulus(0, 0, 0, 0, 1, pat(32'h68));
        checkVal("midreq.late.valid", {31'd0, bus.valid}, 32'd0);
        checkVal("midreq.late.imem_read", {31'd0, bus.imem_read}, 32'd1);
        checkVal("midreq.late.imem_address", bus.imem_address, 32'h60);

        // Fill the queue, then redirect while idle: the new request starts one cycle later.
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(0, 0, 0, 0, 1, pat(32'h60 + 32'(4 * k)));
        end
        checkOutput("idle.full");
        applyStimulus(0, 1, 32'h300, 1, 0, 0);
        checkVal("idle.redir.valid", {31'd0, bus.valid}, 32'd0);
        checkVal("idle.redir.imem_read", {31'd0, bus.imem_read}, 32'd0);
        checkVal("idle.redir.imem_address", bus.imem_address, 32'h300);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkVal("idle.next.imem_read", {31'd0, bus.imem_read}, 32'd1);
        checkVal("idle.next.imem_address", bus.imem_address, 32'h300);

        // Random traffic: memory answers after 0-3 cycles, even when the read went stale.
        applyStimulus(1, 0, 0, 0, 0, 0);
        memPending = 0;
        memAddr    = '0;
        memWait    = 0;
        for (int c = 0; c < 3000; c++) begin
            r   = ($urandom_range(0, 399) == 0);
            rd  = ($urandom_range(0, 29) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'(4 * $urandom_range(0, 3))
                                              : {$urandom(), 2'b00};
            dq  = $urandom_range(0, 1);
            if (!memPending && bus.imem_read) begin
                memPending = 1;
                memAddr    = bus.imem_address;
                memWait    = $urandom_range(0, 3);
            end
            rs   = 0;
            rdat = $urandom();
            if (memPending) begin
                if (memWait == 0) begin
                    rs         = 1;
                    rdat       = pat(memAddr);
                    memPending = 0;
                end else begin
                    memWait--;
                end
            end
            if (r) memPending = 0;
            applyStimulus(r, rd, rpc, dq, rs, rdat);
            checkOutput($sformatf("rand%0d", c));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
